// File: rtl/hilo_ctrl_pkg.sv
// hilo_ctrl_pkg: shared definitions for the HI/LO multiply controller.
//   state_e        - controller FSM state encoding (2 bits)
//   MultLatDefault - default multiplier latency, in rising edges from the
//                    multiplier sampling mult_comeco high to hi/lo capture
package hilo_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } state_e;

    localparam int unsigned MultLatDefault = 33;

endpackage

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: owns the architectural HI/LO registers and sequences a MULT
// through an external fixed-latency multiplier.
//   clock, reset             - single clock, synchronous active-high reset
//   op_start, op_a, op_b     - MULT request and signed operands
//   mult_comeco              - one-cycle start pulse to the multiplier
//   mult_a, mult_b           - operands held stable for the multiplier
//   mult_hi, mult_lo         - multiplier product
//   mthi, mtlo, wr_data      - direct writes into hi / lo (idle only)
//   mfhi_req, mflo_req       - control unit is about to read hi / lo
//   hi, lo                   - architectural HI/LO registers
//   busy, done, stall        - multiply in flight, product landed, hold pipeline
module hilo_ctrl
    import hilo_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = MultLatDefault
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        mult_comeco,
    output logic [31:0] mult_a,
    output logic [31:0] mult_b,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wr_data,
    input  logic        mfhi_req,
    input  logic        mflo_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    localparam int unsigned CntW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MULT_LAT - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            capture;
    logic            accept;
    logic            comeco_q, done_q;
    logic [31:0]     mult_a_q, mult_b_q;
    logic [31:0]     hi_q, lo_q;

    assign accept = (state_q == StIdle) && op_start;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (op_start) state_d = StIssue;
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == CntLast) begin
                    // Counter holds at the last value so it never wraps.
                    capture = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            comeco_q <= 1'b0;
            done_q   <= 1'b0;
            mult_a_q <= '0;
            mult_b_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            // Pulse is high during ISSUE only.
            comeco_q <= accept;
            done_q   <= capture;
            if (accept) begin
                mult_a_q <= op_a;
                mult_b_q <= op_b;
            end
            // Product capture beats a coincident mthi/mtlo; those writes are
            // only honoured while idle (and may coincide with op_start).
            if (capture) begin
                hi_q <= mult_hi;
                lo_q <= mult_lo;
            end else if (state_q == StIdle) begin
                if (mthi) hi_q <= wr_data;
                if (mtlo) lo_q <= wr_data;
            end
        end
    end

    assign mult_comeco = comeco_q;
    assign mult_a      = mult_a_q;
    assign mult_b      = mult_b_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign done        = done_q;
    assign busy        = (state_q != StIdle);
    assign stall       = busy && (mfhi_req || mflo_req || mthi || mtlo || op_start);

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: randomized + directed bench for hilo_ctrl with a behavioural
// multiplier, a cycle-level reference model and a done-driven scoreboard.
module tb_hilo_ctrl;
    import hilo_ctrl_pkg::*;

    localparam int LATI = 33;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        op_start = 1'b0;
    logic [31:0] op_a = '0, op_b = '0;
    logic        mult_comeco;
    logic [31:0] mult_a, mult_b, mult_hi, mult_lo;
    logic        mthi = 1'b0, mtlo = 1'b0;
    logic [31:0] wr_data = '0;
    logic        mfhi_req = 1'b0, mflo_req = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, done, stall;

    hilo_ctrl #(.MULT_LAT(LATI)) dut (
        .clock(clock), .reset(reset), .op_start(op_start), .op_a(op_a), .op_b(op_b),
        .mult_comeco(mult_comeco), .mult_a(mult_a), .mult_b(mult_b),
        .mult_hi(mult_hi), .mult_lo(mult_lo), .mthi(mthi), .mtlo(mtlo),
        .wr_data(wr_data), .mfhi_req(mfhi_req), .mflo_req(mflo_req),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Multiplier: product becomes visible LATI-1 edges after the sampling
    // edge, i.e. exactly in time for a capture LATI edges later; garbage before.
    logic [63:0] mul_res = '0;
    int          mul_cnt = 0;
    always @(posedge clock) begin
        if (reset) begin
            mul_cnt <= 0;
        end else if (mult_comeco) begin
            mul_res <= longint'($signed(mult_a)) * longint'($signed(mult_b));
            mul_cnt <= 1;
        end else if (mul_cnt != 0 && mul_cnt < LATI) begin
            mul_cnt <= mul_cnt + 1;
        end
    end
    assign {mult_hi, mult_lo} = (mul_cnt >= LATI) ? mul_res : 64'hA5A5_5A5A_C3C3_3C3C;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    // Reference model: busy cycles remaining and architectural values.
    logic [31:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
    logic [63:0] m_prod = '0;
    int          m_left = 0;

    always @(negedge clock) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("done_spurious", {63'b0, done}, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("done_hi", {32'b0, hi}, {32'b0, mon_e.hi});
                chk("done_lo", {32'b0, lo}, {32'b0, mon_e.lo});
                chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    task automatic step(input logic st, input logic [31:0] a, input logic [31:0] b,
                        input logic th, input logic tl, input logic [31:0] wd,
                        input logic fh, input logic fl, input logic rs);
        exp_t e;
        @(negedge clock);
        chk("busy", {63'b0, busy}, {63'b0, m_left != 0});
        chk("hi", {32'b0, hi}, {32'b0, m_hi});
        chk("lo", {32'b0, lo}, {32'b0, m_lo});
        chk("comeco", {63'b0, mult_comeco}, {63'b0, m_left == LATI + 1});
        if (m_left != 0) begin
            chk("mult_a", {32'b0, mult_a}, {32'b0, m_a});
            chk("mult_b", {32'b0, mult_b}, {32'b0, m_b});
        end
        reset = rs; op_start = st; op_a = a; op_b = b;
        mthi = th; mtlo = tl; wr_data = wd; mfhi_req = fh; mflo_req = fl;
        #1;
        chk("stall", {63'b0, stall}, {63'b0, (m_left != 0) && (st || th || tl || fh || fl)});
        @(posedge clock);
        if (rs) begin
            m_hi = '0; m_lo = '0; m_a = '0; m_b = '0; m_left = 0;
            sb_q.delete();
        end else if (m_left == 0) begin
            if (th) m_hi = wd;
            if (tl) m_lo = wd;
            if (st) begin
                m_a = a; m_b = b;
                m_prod = longint'($signed(a)) * longint'($signed(b));
                m_left = LATI + 1;
                e.hi = m_prod[63:32];
                e.lo = m_prod[31:0];
                e.cyc = cyc + LATI + 2;
                sb_q.push_back(e);
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_hi = m_prod[63:32];
                m_lo = m_prod[31:0];
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 4))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'd9, 32'd9, 1'b1, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b1);
        idle(2);

        // 3 * 5
        step(1'b1, 32'd3, 32'd5, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        idle(40);
        // -1 * 2, with mfhi during WAIT and after done
        step(1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        idle(6);
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(36);
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);

        // mthi while idle, then while busy
        step(1'b0, '0, '0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hFFFF_FFFB, 32'd9, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        idle(3);
        step(1'b0, '0, '0, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
        idle(8);
        step(1'b1, 32'd7, 32'd7, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        idle(30);

        // start with mthi together; then writes on the capture edge
        step(1'b1, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100 && m_left != 1; i++) idle(1);
        step(1'b0, '0, '0, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        idle(3);

        // reset mid-WAIT aborts the multiply
        step(1'b1, 32'd100, 32'd200, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        idle(12);
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(40);

        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 7) == 0, pick_op(), pick_op(),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 199) == 0);
        end
        idle(40);
        chk("sb_drain", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 Parameter: MULT_LAT, 33, rising edges from the multiplier sampling mult_comeco high to hi/lo capture; minimum 2.
REQ-002 clock  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 op_start  in  1  control unit requests a MULT when high for one cycle.
REQ-005 op_a, op_b  in  32 each  signed multiplicand and multiplier, sampled with op_start.
REQ-006 mult_comeco  out  1  registered one-cycle start pulse to the multiplier.
REQ-007 mult_a, mult_b  out  32 each  registered operands driven to the multiplier.
REQ-008 mult_hi, mult_lo  in  32 each  multiplier result outputs.
REQ-009 mthi, mtlo  in  1 each  write wr_data into hi or lo.
REQ-010 wr_data  in  32  data for mthi/mtlo.
REQ-011 mfhi_req, mflo_req  in  1 each  control unit is about to read hi or lo.
REQ-012 hi, lo  out  32 each  architectural HI/LO registers.
REQ-013 busy  out  1  multiply in flight.
REQ-014 done  out  1  one-cycle pulse; new product is visible on hi/lo.
REQ-015 stall  out  1  combinational; control unit holds its state while high.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT; 2-bit encoding.
REQ-017 IDLE with op_start=1: latch op_a/op_b into mult_a/mult_b; go to ISSUE.
REQ-018 ISSUE: mult_comeco=1 for exactly this cycle, mult_a/mult_b stable; clear counter; go to WAIT.
REQ-019 WAIT: counter increments every cycle; mult_a/mult_b held constant.
REQ-020 WAIT with counter==MULT_LAT-1: hi<=mult_hi and lo<=mult_lo on that edge; done=1 in the following cycle; go to IDLE.
REQ-021 Latency: done is high in cycle 2+MULT_LAT after the op_start sampling edge, which is cycle 35 at the default.
REQ-022 busy=1 exactly in ISSUE and WAIT; mult_comeco=0 in IDLE and WAIT.
REQ-023 op_start while busy: ignored, with no re-issue and no operand update.
REQ-024 mthi/mtlo in IDLE: hi or lo <= wr_data on the next edge; both may be asserted together.
REQ-025 mthi/mtlo while busy: ignored; hi and lo are unchanged.
REQ-026 stall = busy AND (mfhi_req OR mflo_req OR mthi OR mtlo OR op_start).
REQ-027 mfhi_req/mflo_req never modify state.
REQ-028 IDLE with op_start and mthi together: the mthi write occurs and the multiply starts; the later product overwrites hi.
REQ-029 Capture edge with mthi/mtlo also asserted: the product wins; the write is dropped and stall is high.
REQ-030 Counter width ceil(log2(MULT_LAT)); no wrap-around before capture.

Reset
REQ-031 reset=1 at an edge: state=IDLE, counter=0, hi=0, lo=0, mult_a=0, mult_b=0, mult_comeco=0, done=0; busy=0 follows.
REQ-032 reset has priority over op_start, mthi and mtlo in the same cycle.
REQ-033 Reset mid-operation aborts the multiply: no done and no capture; the multiplier shares the same reset.

Structure
REQ-034 Shared package holds the FSM state encoding and the MULT_LAT default; datapath and control reference it.
REQ-035 No sub-module; the multiplier stays instantiated beside this block at datapath level, wired through the mult_* ports.

Verification
REQ-036 op_a=3, op_b=5, op_start one cycle -> mult_comeco one cycle; done in cycle 35; hi=0x00000000, lo=0x0000000F.
REQ-037 op_a=0xFFFFFFFF, op_b=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE; busy high for exactly 34 cycles.
REQ-038 mfhi_req=1 at WAIT cycle 5 -> stall=1 that cycle, hi unchanged; mfhi_req after done -> stall=0.
REQ-039 IDLE, mthi=1 with wr_data=0xDEADBEEF -> hi=0xDEADBEEF next cycle; same request while busy -> stall=1, hi unchanged.
REQ-040 op_start again at WAIT cycle 10 with op_a=7, op_b=7 -> ignored; result remains that of the first operands.
REQ-041 reset=1 at WAIT cycle 12 -> next cycle hi=lo=0, busy=0, state IDLE; no done within 40 cycles.
